// File: rtl/grant_watchdog.sv
// grant_watchdog: per-grant hold-time watchdog.
// Counts time-base ticks while one requester holds the grant. A grant held
// for `limit` ticks is revoked, and an expiry pulse is raised. After the
// arbiter drops that grant, the offending requester is masked for `holdoff`
// ticks.
module grant_watchdog #(
  parameter int unsigned limit       = 16,
  parameter int unsigned holdoff     = 2,
  parameter int unsigned index_width = 2
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          tick,
  input  logic                          grant,
  input  logic [index_width-1:0]        grant_index,
  output logic                          revoke,
  output logic                          expire,
  output logic [index_width-1:0]        expired_index,
  output logic [(2**index_width)-1:0]   mask,
  output logic [$clog2(limit+1)-1:0]    elapsed
);

  localparam int unsigned requesters    = 2 ** index_width;
  localparam int unsigned elapsed_width = $clog2(limit + 1);
  localparam int unsigned hold_width    = (holdoff > 0) ? $clog2(holdoff + 1) : 1;

  localparam logic [elapsed_width-1:0] limit_value = elapsed_width'(limit);
  localparam logic [elapsed_width-1:0] last_tick   = elapsed_width'(limit - 1);
  localparam logic [hold_width-1:0]    hold_last   =
    hold_width'((holdoff == 0) ? 0 : holdoff - 1);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    REVOKE,
    HOLDOFF
  } state_t;

  state_t                   state;
  logic [index_width-1:0]   held_index;
  logic [hold_width-1:0]    hold_count;
  logic [requesters-1:0]    expired_onehot;

  // One-hot decode of the captured expiry index, used to load the mask.
  always_comb begin
    expired_onehot = '0;
    expired_onehot[expired_index] = 1'b1;
  end

  // Watchdog state machine. All outputs are registered here. The order of
  // tests in HOLD sets the priority: a grant drop wins over an index
  // change, and an index change wins over the limit tick.
  always_ff @(posedge clock) begin
    expire <= 1'b0;
    if (reset) begin
      state         <= IDLE;
      held_index    <= '0;
      hold_count    <= '0;
      revoke        <= 1'b0;
      expired_index <= '0;
      mask          <= '0;
      elapsed       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          elapsed <= '0;
          if (grant) begin
            state      <= HOLD;
            held_index <= grant_index;
          end
        end

        HOLD: begin
          if (!grant) begin
            state   <= IDLE;
            elapsed <= '0;
          end else if (grant_index != held_index) begin
            held_index <= grant_index;
            elapsed    <= '0;
          end else if (tick) begin
            if (elapsed == last_tick) begin
              state         <= REVOKE;
              elapsed       <= limit_value;
              expire        <= 1'b1;
              expired_index <= held_index;
              revoke        <= 1'b1;
            end else begin
              elapsed <= elapsed + 1'b1;
            end
          end
        end

        REVOKE: begin
          if (!grant) begin
            revoke  <= 1'b0;
            elapsed <= '0;
            if (holdoff > 0) begin
              state      <= HOLDOFF;
              hold_count <= '0;
              mask       <= expired_onehot;
            end else begin
              state <= IDLE;
            end
          end
        end

        HOLDOFF: begin
          // A new grant seen here is not timed; IDLE picks it up next cycle.
          if (tick) begin
            if (hold_count == hold_last) begin
              state      <= IDLE;
              mask       <= '0;
              hold_count <= '0;
            end else begin
              hold_count <= hold_count + 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
